// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bin2bcd_pkg                                                   |
// | Purpose  : Shared state encoding, error nibble and overflow-limit helper |
// |            for the sequential binary-to-BCD converter.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package bin2bcd_pkg;

   // Two-state converter: waiting for a request, or iterating shift-and-add-3
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Digit shown on every position when the input cannot be represented
   localparam logic [3:0] BCD_ERR_NIBBLE = 4'hE;

   // Largest value representable with ndig decimal digits (10^ndig - 1)
   function automatic logic [31:0] bcd_max_value(input int unsigned ndig);
      logic [31:0] p;
      p = 32'd1;
      for (int unsigned i = 0; i < ndig; i++) begin
         p = p * 32'd10;
      end
      return p - 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bcd_add3                                                      |
// | Purpose  : Combinational double-dabble digit corrector: adds 3 to a BCD  |
// |            nibble of 5 or more so the following shift carries properly.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bcd_add3 (
   input  logic [3:0] d_i,
   output logic [3:0] d_o
);

   // A digit never exceeds 9 before correction, so the 4-bit sum cannot wrap
   assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bin2bcd_seq                                                   |
// | Purpose  : Iterative (double dabble) binary-to-packed-BCD converter with |
// |            held registered result and all-E overflow pattern.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BIN_W = 14,
   parameter int NDIG  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [BIN_W-1:0]    bin,
   output logic                busy,
   output logic                done,
   output logic [4*NDIG-1:0]   bcd,
   output logic                ovf
);

   localparam int BCD_W = 4 * NDIG;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   localparam logic [31:0]      MAX_VAL  = bcd_max_value(NDIG);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SR_W-1:0]      sr_q, sr_d;
   logic                 ovf_flag_q, ovf_flag_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic                 ovf_q, ovf_d;

   logic [BCD_W-1:0]     w_corr;
   logic [SR_W-1:0]      w_sr_corr;
   logic [SR_W-1:0]      w_sr_shift;
   logic                 w_bin_ovf;

   // Add-3 correction on every BCD digit of the shift register
   for (genvar g = 0; g < NDIG; g++) begin : g_add3
      bcd_add3 u_add3 (
         .d_i (sr_q[BIN_W + 4*g +: 4]),
         .d_o (w_corr[4*g +: 4])
      );
   end

   // One iteration = correct the digits, then shift the whole register left
   assign w_sr_corr  = {w_corr, sr_q[BIN_W-1:0]};
   assign w_sr_shift = w_sr_corr << 1;

   // Range check done on the raw input so it is latched together with it
   assign w_bin_ovf = ({{(32-BIN_W){1'b0}}, bin} > MAX_VAL);

   // State, datapath and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sr_q       <= '0;
         ovf_flag_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         ovf_flag_q <= ovf_flag_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
      end
   end

   // Next-state logic: accept in IDLE, iterate BIN_W times, publish result
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      ovf_flag_d = ovf_flag_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               sr_d       = {{BCD_W{1'b0}}, bin};
               ovf_flag_d = w_bin_ovf;
               cnt_d      = '0;
               busy_d     = 1'b1;
               state_d    = SHIFT;
            end
         end

         SHIFT: begin
            sr_d  = w_sr_shift;
            cnt_d = cnt_q + 1'b1;
            // The final shift still runs for out-of-range inputs so latency
            // does not depend on the data
            if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               ovf_d   = ovf_flag_q;
               bcd_d   = ovf_flag_q ? {NDIG{BCD_ERR_NIBBLE}}
                                    : w_sr_shift[SR_W-1 -: BCD_W];
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bin2bcd_seq                                                |
// | Purpose  : Self-checking bench for bin2bcd_seq with a decimal-arithmetic |
// |            reference model and directed vectors.                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bin2bcd_seq;

   localparam int BIN_W = 14;
   localparam int NDIG  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [BIN_W-1:0]  bin;
   logic              busy;
   logic              done;
   logic [15:0]       bcd;
   logic              ovf;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt = 0;

   bin2bcd_seq #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   // Expected decimal rendering of a value, or all-E when out of range
   function automatic logic [15:0] dec(input int v);
      if (v > 9999) return 16'hEEEE;
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Reference model: an accepted value appears BIN_W edges later
   logic        m_valid = 1'b0;
   logic        m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
   logic [15:0] m_bcd = 16'h0;
   int          m_left = 0;
   int          m_val = 0;

   always @(posedge clk) begin
      cyc++;
      if (done) done_cnt++;
      if (rst) begin
         m_valid = 1'b1;
         m_busy  = 1'b0;
         m_done  = 1'b0;
         m_bcd   = 16'h0;
         m_ovf   = 1'b0;
         m_left  = 0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               m_busy = 1'b0;
               m_bcd  = dec(m_val);
               m_ovf  = (m_val > 9999);
            end
         end else if (start) begin
            m_val  = int'(bin);
            m_left = BIN_W;
            m_busy = 1'b1;
         end
      end
   end

   // Cycle-by-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (m_valid) begin
         n_cmp++;
         if (busy !== m_busy || done !== m_done || bcd !== m_bcd || ovf !== m_ovf) begin
            n_err++;
            $display("FAIL model_cycle t=%0t actual busy=%b done=%b bcd=%h ovf=%b required busy=%b done=%b bcd=%h ovf=%b",
                     $time, busy, done, bcd, ovf, m_busy, m_done, m_bcd, m_ovf);
         end
         n_cmp++;
         if (busy === 1'b1 && done === 1'b1) begin
            n_err++;
            $display("FAIL busy_done_overlap t=%0t actual both high required not both", $time);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Called on the falling edge right after the accepting edge
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout actual=no_done required=done within 40 cycles");
      end
   endtask

   task automatic do_conv(input int v, input logic [15:0] expb, input logic expo);
      int lat, bcnt;
      @(negedge clk);
      bin   = BIN_W'(v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bcnt);
      check($sformatf("bcd_%0d", v), 32'(bcd), 32'(expb));
      check($sformatf("ovf_%0d", v), 32'(ovf), 32'(expo));
      check($sformatf("latency_%0d", v), 32'(lat), 32'd14);
      check($sformatf("busy_cycles_%0d", v), 32'(bcnt), 32'd14);
   endtask

   initial begin
      int lat, bcnt, d0, t1;
      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_bcd",  32'(bcd),  32'd0);
      check("reset_ovf",  32'(ovf),  32'd0);

      // Basic, boundary and overflow conversions
      do_conv(1234,  16'h1234, 1'b0);
      do_conv(0,     16'h0000, 1'b0);
      do_conv(9,     16'h0009, 1'b0);
      do_conv(9999,  16'h9999, 1'b0);
      do_conv(10000, 16'hEEEE, 1'b1);
      do_conv(16383, 16'hEEEE, 1'b1);

      // Request pulsed mid-conversion is ignored
      @(negedge clk);
      bin   = 14'd4321;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      d0 = done_cnt;
      repeat (4) @(negedge clk);
      bin   = 14'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bin   = '0;
      wait_done(lat, bcnt);
      check("ignored_start_bcd", 32'(bcd), 32'h4321);
      repeat (20) @(negedge clk);
      check("ignored_start_done_pulses", 32'(done_cnt - d0), 32'd1);

      // Back-to-back conversions with start held high
      @(negedge clk);
      bin   = 14'd42;
      start = 1'b1;
      @(negedge clk);
      bin = 14'd777;
      wait_done(lat, bcnt);
      check("b2b_first_bcd", 32'(bcd), 32'h0042);
      t1 = cyc;
      @(negedge clk);
      wait_done(lat, bcnt);
      start = 1'b0;
      check("b2b_second_bcd", 32'(bcd), 32'h0777);
      check("b2b_gap", 32'(cyc - t1), 32'd15);
      repeat (20) @(negedge clk);

      // Reset in the middle of a conversion
      @(negedge clk);
      bin   = 14'd8765;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      d0 = done_cnt;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_bcd",  32'(bcd),  32'd0);
      repeat (20) @(negedge clk);
      check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
      do_conv(55, 16'h0055, 1'b0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=still running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
